// File: rtl/instr_fetch.sv
// Multicycle instruction fetch stage: owns the PC, runs the req/ack memory port, and holds the instruction for decode.
// Optional retired-fetch counter enabled by defining FETCH_PERF_EN.
module instr_fetch #(
    parameter int unsigned      PC_W     = 32,
    parameter logic [PC_W-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic [5:0]      op,
    output logic [PC_W-1:0] instr_pc,
    output logic [PC_W-1:0] pc_plus4,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [31:0]     fetch_count
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] addr_q;
    logic [31:0]     ir_q;
    logic [PC_W-1:0] instr_pc_q;
    logic            valid_q;
    logic            req_q;
    logic [PC_W-1:0] redir_pc_d;

    assign redir_pc_d = redirect_pc & ~PC_W'(3);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            ir_q       <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (redirect) begin
                        pc_q  <= redir_pc_d;
                        req_q <= 1'b1;
                        // An outstanding request must finish at its original address.
                        if (req_q && !imem_ack)
                            state_q <= S_DRAIN;
                        else
                            addr_q <= redir_pc_d;
                    end else if (req_q && imem_ack) begin
                        ir_q       <= imem_rdata;
                        instr_pc_q <= addr_q;
                        pc_q       <= addr_q + PC_W'(4);
                        valid_q    <= 1'b1;
                        req_q      <= 1'b0;
                        state_q    <= S_HOLD;
                    end else begin
                        req_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        pc_q    <= redir_pc_d;
                        addr_q  <= redir_pc_d;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= S_FETCH;
                    end else if (instr_ready) begin
                        addr_q  <= pc_q;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            pc_q   <= redir_pc_d;
                            addr_q <= redir_pc_d;
                        end else begin
                            addr_q <= pc_q;
                        end
                        state_q <= S_FETCH;
                    end else if (redirect) begin
                        pc_q <= redir_pc_d;
                    end
                end
                default: begin
                    state_q <= S_FETCH;
                    valid_q <= 1'b0;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (reset)
            count_q <= '0;
        else if (state_q == S_HOLD && valid_q && instr_ready && !redirect)
            count_q <= count_q + 32'd1;
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = '0;
`endif

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr       = ir_q;
    assign op          = ir_q[31:26];
    assign instr_pc    = instr_pc_q;
    assign pc_plus4    = instr_pc_q + PC_W'(4);
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory responder with variable latency, delivery-order model, directed scenarios.
module tb_instr_fetch;

    localparam int unsigned PC_W     = 32;
    localparam logic [31:0] RESET_PC = 32'h100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] fetch_count;

    int errors = 0;
    int checks = 0;
    int lat = 1;

    instr_fetch #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .op(op), .instr_pc(instr_pc), .pc_plus4(pc_plus4),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h100) return 32'h8C020004;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid;
        int n;
        n = 0;
        while (instr_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("valid_timeout", 32'(instr_valid), 32'd1);
    endtask

    task automatic accept;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    // Memory responder: acks the lat-th cycle a request is seen.
    initial begin
        int waitc;
        waitc = 0;
        forever begin
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            if (imem_req === 1'b1 && !reset) begin
                waitc++;
                if (waitc >= lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = memfn(imem_addr);
                    waitc      = 0;
                end
            end else begin
                waitc = 0;
            end
        end
    end

    // Model: the next delivered instruction's address and the retired count follow from handshakes and redirects.
    initial begin
        logic [31:0] exp_pc;
        logic [31:0] exp_cnt;
        logic [31:0] w;
        logic [31:0] prev_addr;
        logic        prev_pend;
        exp_pc    = RESET_PC;
        exp_cnt   = 0;
        prev_pend = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (prev_pend) begin
                    chk("req_held", 32'(imem_req), 32'd1);
                    chk("addr_held", imem_addr, prev_addr);
                end
                if (instr_valid) begin
                    w = memfn(instr_pc);
                    chk("instr_pc_order", instr_pc, exp_pc);
                    chk("instr_word", instr, w);
                    chk("op_field", 32'(op), 32'(w[31:26]));
                    chk("pc_plus4", pc_plus4, instr_pc + 32'd4);
                end
`ifdef FETCH_PERF_EN
                chk("fetch_count_model", fetch_count, exp_cnt);
`else
                chk("fetch_count_zero", fetch_count, 32'd0);
`endif
            end
            if (reset) begin
                exp_pc  = RESET_PC;
                exp_cnt = 0;
            end else if (redirect) begin
                exp_pc = redirect_pc & ~32'd3;
            end else if (instr_valid && instr_ready) begin
                exp_pc  = instr_pc + 32'd4;
                exp_cnt = exp_cnt + 1;
            end
            prev_pend = !reset && imem_req && !imem_ack;
            prev_addr = imem_addr;
        end
    end

    initial begin
        int n;
        logic [31:0] held;
        logic [31:0] cnt_save;
        repeat (3) tick();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_addr", imem_addr, 32'h100);
        chk("rst_instr", instr, 32'd0);
        reset = 1'b0;

        // First fetch after reset, latency 1.
        n = 0;
        while (imem_req !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("first_req_cycle", 32'(n), 32'd1);
        chk("first_req_addr", imem_addr, 32'h100);
        wait_valid();
        chk("t1_instr", instr, 32'h8C020004);
        chk("t1_op", 32'(op), 32'h23);
        chk("t1_instr_pc", instr_pc, 32'h100);
        chk("t1_pc_plus4", pc_plus4, 32'h104);

        // Sequential fetches with consumer stall on the second.
        accept();
        wait_valid();
        chk("t2_instr_pc", instr_pc, 32'h104);
        held = instr;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_stall_valid", 32'(instr_valid), 32'd1);
            chk("t2_stall_instr", instr, held);
        end
        accept();
        wait_valid();
        chk("t3_instr_pc", instr_pc, 32'h108);
        accept();
`ifdef FETCH_PERF_EN
        chk("t3_count", fetch_count, 32'd3);
`else
        chk("t3_count", fetch_count, 32'd0);
`endif

        // Redirect mid-request with latency 4 forces a drain at the old address.
        lat = 4;
        wait_valid();
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        wait_valid();
        chk("t4_start_pc", instr_pc, 32'h100);
        accept();
        chk("t4_req_addr", imem_addr, 32'h104);
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            chk("t4_drain_addr", imem_addr, 32'h104);
            if (imem_ack || n >= 10) break;
            n++;
        end
        if (n >= 10) chk("t4_ack_timeout", 32'd0, 32'd1);
        wait_valid();
        chk("t4_redirect_pc", instr_pc, 32'h200);

        // Redirect in HOLD beats a simultaneous ready; low bits dropped.
        cnt_save = fetch_count;
        redirect = 1'b1;
        redirect_pc = 32'h3;
        instr_ready = 1'b1;
        tick();
        redirect = 1'b0;
        instr_ready = 1'b0;
        chk("t5_valid_drop", 32'(instr_valid), 32'd0);
        chk("t5_count_same", fetch_count, cnt_save);
        wait_valid();
        chk("t5_instr_pc", instr_pc, 32'h0);

        // PC wrap at the top of the address space.
        lat = 1;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        wait_valid();
        chk("t6_instr_pc", instr_pc, 32'hFFFF_FFFC);
        chk("t6_pc_plus4", pc_plus4, 32'h0);
        accept();
        chk("t6_next_req", 32'(imem_req), 32'd1);
        chk("t6_next_addr", imem_addr, 32'h0);
        wait_valid();
        chk("t6_wrap_pc", instr_pc, 32'h0);

        // Reset while draining abandons the request.
        lat = 4;
        accept();
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h300;
        tick();
        redirect = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t7_req", 32'(imem_req), 32'd0);
        chk("t7_valid", 32'(instr_valid), 32'd0);
        chk("t7_count", fetch_count, 32'd0);
        chk("t7_addr", imem_addr, 32'h100);
        wait_valid();
        chk("t7_instr_pc", instr_pc, 32'h100);
        chk("t7_instr", instr, 32'h8C020004);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
